// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer:
// opcode class indices, FSM state encoding, flag bit indices.
package ctrl_seq_pkg;

  localparam int OPC_W    = 13;

  localparam int C_NOP    = 0;
  localparam int C_ALU_RR = 1;
  localparam int C_ALU_RI = 2;
  localparam int C_CMP    = 3;
  localparam int C_LOAD   = 4;
  localparam int C_STORE  = 5;
  localparam int C_BR_U   = 6;
  localparam int C_BR_EQ  = 7;
  localparam int C_BR_NE  = 8;
  localparam int C_BR_GE  = 9;
  localparam int C_BR_GT  = 10;
  localparam int C_INPUT  = 11;
  localparam int C_HALT   = 12;

  // branch classes occupy one contiguous run of indices
  localparam int BR_N     = C_BR_GT - C_BR_U + 1;

  localparam logic [OPC_W-1:0] OPC_NOP = OPC_W'(1) << C_NOP;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int F_OVF   = 0;
  localparam int F_NEG   = 1;
  localparam int F_ZERO  = 2;
  localparam int F_CARRY = 3;

  function automatic logic onehot(input logic [OPC_W-1:0] v);
    return (v != '0) && ((v & (v - OPC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Fetch, datapath-control and memory-status bundle.
// master: fetch/datapath side; slave: the sequencer.
interface ctrl_seq_if #(
  parameter int REG_W  = 2,
  parameter int FLAG_W = 4
) ();
  import ctrl_seq_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [OPC_W-1:0]  opc_in;
  logic [REG_W-1:0]  rx_in;
  logic [REG_W-1:0]  ry_in;
  logic [FLAG_W-1:0] flag_in;
  logic              mem_busy;
  logic [REG_W-1:0]  sel_a;
  logic [REG_W-1:0]  sel_b;
  logic [REG_W-1:0]  sel_w;
  logic              reg_we;
  logic              alu_en;
  logic              imm_sel;
  logic              mem_rd;
  logic              mem_wr;
  logic              in_sel;
  logic              pc_load;
  logic [FLAG_W-1:0] flags_q;
  logic [2:0]        phase;
  logic              halted;
  logic              illegal;

  modport master (
    output instr_valid, opc_in, rx_in, ry_in,
    output flag_in, mem_busy,
    input  instr_ready, sel_a, sel_b, sel_w,
    input  reg_we, alu_en, imm_sel, mem_rd,
    input  mem_wr, in_sel, pc_load, flags_q,
    input  phase, halted, illegal
  );

  modport slave (
    input  instr_valid, opc_in, rx_in, ry_in,
    input  flag_in, mem_busy,
    output instr_ready, sel_a, sel_b, sel_w,
    output reg_we, alu_en, imm_sel, mem_rd,
    output mem_wr, in_sel, pc_load, flags_q,
    output phase, halted, illegal
  );

endinterface

// File: rtl/control_sequencer_branch_eval.sv
// Combinational branch resolution.
// br: one-hot BR_U..BR_GT slice; flags: O,N,Z; taken out.
module branch_eval
  import ctrl_seq_pkg::*;
(
  input  logic [BR_N-1:0] br,
  input  logic [2:0]      flags,
  output logic            taken
);

  logic z;
  logic ge;

  assign z  = flags[F_ZERO];
  assign ge = ~(flags[F_NEG] ^ flags[F_OVF]);

  assign taken = br[C_BR_U  - C_BR_U]
               | (br[C_BR_EQ - C_BR_U] &  z)
               | (br[C_BR_NE - C_BR_U] & ~z)
               | (br[C_BR_GE - C_BR_U] &  ge)
               | (br[C_BR_GT - C_BR_U] & ~z & ge);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Ports: clk, rst_n (sync, active low), bus (ctrl_seq_if.slave).
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int REG_W  = 2,
  parameter int FLAG_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  ctrl_seq_if.slave bus
);

  if (FLAG_W < 4) begin : g_flag_w_check
    $error("control_sequencer: FLAG_W must be >= 4");
  end

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [REG_W-1:0]  rx_q, rx_d, ry_q, ry_d;
  logic [FLAG_W-1:0] flg_q, flg_d;
  logic              ill_d, taken;
  logic              ex_d, mem_d, wb_d;

  logic              ready_q, alu_q, imm_q;
  logic              we_q, rd_q, wr_q, in_q;
  logic              pc_q, halt_q, ill_q;
  logic [REG_W-1:0]  sel_a_q, sel_b_q, sel_w_q;

  // flags only change at the end of EXEC, so the value
  // seen while entering EXEC is the one branches use
  branch_eval u_br (
    .br    (opc_d[C_BR_GT:C_BR_U]),
    .flags (flg_q[2:0]),
    .taken (taken)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    flg_d   = flg_q;
    ill_d   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          state_d = S_DECODE;
          opc_d   = bus.opc_in;
          rx_d    = bus.rx_in;
          ry_d    = bus.ry_in;
        end
      end
      S_DECODE: begin
        if (onehot(opc_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
          opc_d   = OPC_NOP;
          ill_d   = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (opc_q[C_ALU_RR] | opc_q[C_ALU_RI] | opc_q[C_CMP])
          flg_d = bus.flag_in;
        unique case (1'b1)
          opc_q[C_ALU_RR],
          opc_q[C_ALU_RI],
          opc_q[C_INPUT]:  state_d = S_WB;
          opc_q[C_LOAD],
          opc_q[C_STORE]:  state_d = S_MEM;
          opc_q[C_HALT]:   state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!bus.mem_busy)
          state_d = opc_q[C_LOAD] ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign ex_d  = (state_d == S_EXEC);
  assign mem_d = (state_d == S_MEM);
  assign wb_d  = (state_d == S_WB);

  // strobes are decoded from the next state so that
  // every output leaves a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= OPC_NOP;
      rx_q    <= '0;
      ry_q    <= '0;
      flg_q   <= '0;
      ready_q <= 1'b1;
      alu_q   <= 1'b0;
      imm_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      in_q    <= 1'b0;
      pc_q    <= 1'b0;
      halt_q  <= 1'b0;
      ill_q   <= 1'b0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      sel_w_q <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      flg_q   <= flg_d;
      ready_q <= (state_d == S_FETCH);
      alu_q   <= ex_d & (opc_d[C_ALU_RR] | opc_d[C_ALU_RI]
                       | opc_d[C_CMP] | opc_d[C_LOAD]
                       | opc_d[C_STORE]);
      imm_q   <= ex_d & (opc_d[C_ALU_RI] | opc_d[C_LOAD]
                       | opc_d[C_STORE]);
      pc_q    <= ex_d & taken;
      rd_q    <= mem_d & opc_d[C_LOAD];
      wr_q    <= mem_d & opc_d[C_STORE];
      we_q    <= wb_d;
      in_q    <= wb_d & opc_d[C_INPUT];
      halt_q  <= (state_d == S_HALT);
      ill_q   <= ill_d;
      sel_a_q <= ex_d ? rx_d : '0;
      sel_b_q <= ex_d ? ry_d : '0;
      sel_w_q <= wb_d ? rx_d : '0;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_en      = alu_q;
  assign bus.imm_sel     = imm_q;
  assign bus.reg_we      = we_q;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_wr      = wr_q;
  assign bus.in_sel      = in_q;
  assign bus.pc_load     = pc_q;
  assign bus.halted      = halt_q;
  assign bus.illegal     = ill_q;
  assign bus.sel_a       = sel_a_q;
  assign bus.sel_b       = sel_b_q;
  assign bus.sel_w       = sel_w_q;
  assign bus.flags_q     = flg_q;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a
// write-back scoreboard and per-instruction strobe model.
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ctrl_seq_if #(.REG_W(2), .FLAG_W(4)) bus ();

  control_sequencer #(.REG_W(2), .FLAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [1:0] wb_q [$];
  logic [3:0] mflags;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OPC_W-1:0] op(input int c);
    logic [OPC_W-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic br_model(input logic [OPC_W-1:0] o,
                                    input logic [3:0] f);
    logic z, ge;
    z  = f[2];
    ge = (f[1] == f[0]);
    if (o[C_BR_U])  return 1'b1;
    if (o[C_BR_EQ]) return z;
    if (o[C_BR_NE]) return !z;
    if (o[C_BR_GE]) return ge;
    if (o[C_BR_GT]) return !z && ge;
    return 1'b0;
  endfunction

  // every write-back pops the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.reg_we === 1'b1) begin
      if (wb_q.size() == 0)
        chk("wb_pending", 32'(wb_q.size()), 32'd1);
      else
        chk("wb_sel_w", 32'(bus.sel_w), 32'(wb_q.pop_front()));
    end
  end

  task automatic run(input string nm,
                     input logic [OPC_W-1:0] opc,
                     input logic [1:0] rx,
                     input logic [1:0] ry,
                     input logic [3:0] fl,
                     input int busy);
    int cyc = 2, memk = 0;
    int n_we = 0, n_pc = 0, n_rd = 0, n_wr = 0;
    int n_alu = 0, n_imm = 0, n_in = 0, n_ill = 0;
    int wb_cyc = 0, pc_cyc = 0, e_end, e_wb;
    logic ok1, tk, wrt, alu3, done;
    logic [3:0] selab;
    ok1  = $onehot(opc);
    tk   = ok1 && br_model(opc, mflags);
    alu3 = opc[C_ALU_RR] || opc[C_ALU_RI] || opc[C_INPUT];
    wrt  = ok1 && (alu3 || opc[C_LOAD]);
    if (wrt) wb_q.push_back(rx);
    done  = 1'b0;
    selab = '0;
    bus.instr_valid = 1'b1;
    bus.opc_in = opc;
    bus.rx_in = rx;
    bus.ry_in = ry;
    bus.flag_in = fl;
    bus.mem_busy = 1'b0;
    step();
    bus.instr_valid = 1'b0;
    chk({nm, "_accept"}, 32'(bus.phase), 32'(S_DECODE));
    for (int k = 0; k < 40; k++) begin
      if (bus.reg_we)  begin n_we++; wb_cyc = cyc; end
      if (bus.pc_load) begin n_pc++; pc_cyc = cyc; end
      if (bus.mem_rd)  n_rd++;
      if (bus.mem_wr)  n_wr++;
      if (bus.alu_en)  n_alu++;
      if (bus.imm_sel) n_imm++;
      if (bus.in_sel)  n_in++;
      if (bus.illegal) n_ill++;
      if (bus.phase == S_EXEC) selab = {bus.sel_a, bus.sel_b};
      if (bus.phase == S_FETCH || bus.phase == S_HALT) begin
        done = 1'b1;
        break;
      end
      bus.mem_busy = (bus.phase == S_MEM) && (memk < busy);
      if (bus.phase == S_MEM) memk++;
      step();
      cyc++;
    end
    bus.mem_busy = 1'b0;
    if (!ok1)                e_end = 3;
    else if (opc[C_HALT])    e_end = 4;
    else if (alu3)           e_end = 5;
    else if (opc[C_LOAD])    e_end = 6 + busy;
    else if (opc[C_STORE])   e_end = 5 + busy;
    else                     e_end = 4;
    e_wb = !ok1 ? 0 : alu3 ? 4 : opc[C_LOAD] ? 5 + busy : 0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_end_cyc"}, 32'(cyc), 32'(e_end));
    chk({nm, "_wb_cyc"}, 32'(wb_cyc), 32'(e_wb));
    chk({nm, "_n_we"}, 32'(n_we), 32'(wrt));
    chk({nm, "_pc_cyc"}, 32'(pc_cyc), tk ? 32'd3 : 32'd0);
    chk({nm, "_n_pc"}, 32'(n_pc), 32'(tk));
    chk({nm, "_n_alu"}, 32'(n_alu), 32'(ok1 &&
        (opc[C_ALU_RR] || opc[C_ALU_RI] || opc[C_CMP]
         || opc[C_LOAD] || opc[C_STORE])));
    chk({nm, "_n_imm"}, 32'(n_imm), 32'(ok1 &&
        (opc[C_ALU_RI] || opc[C_LOAD] || opc[C_STORE])));
    chk({nm, "_n_in"}, 32'(n_in), 32'(ok1 && opc[C_INPUT]));
    chk({nm, "_n_rd"}, 32'(n_rd),
        (ok1 && opc[C_LOAD]) ? 32'(busy + 1) : 32'd0);
    chk({nm, "_n_wr"}, 32'(n_wr),
        (ok1 && opc[C_STORE]) ? 32'(busy + 1) : 32'd0);
    chk({nm, "_n_ill"}, 32'(n_ill), 32'(!ok1));
    if (ok1)
      chk({nm, "_sel_ab"}, 32'(selab), 32'({rx, ry}));
    if (ok1 && (opc[C_ALU_RR] || opc[C_ALU_RI] || opc[C_CMP]))
      mflags = fl;
    chk({nm, "_flags"}, 32'(bus.flags_q), 32'(mflags));
  endtask

  initial begin : main
    int bad;
    mflags = '0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opc_in = '0;
    bus.rx_in = '0;
    bus.ry_in = '0;
    bus.flag_in = '0;
    bus.mem_busy = 1'b0;
    step();
    step();
    chk("rst_phase", 32'(bus.phase), 32'(S_FETCH));
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_flags", 32'(bus.flags_q), 32'd0);
    chk("rst_halt_ill", 32'({bus.halted, bus.illegal}), 32'd0);
    chk("rst_strobes", 32'({bus.reg_we, bus.alu_en, bus.imm_sel,
        bus.mem_rd, bus.mem_wr, bus.in_sel, bus.pc_load}), 32'd0);
    chk("rst_sels", 32'({bus.sel_a, bus.sel_b, bus.sel_w}), 32'd0);
    rst_n = 1'b1;

    run("alu_rr", op(C_ALU_RR), 2'd2, 2'd1, 4'b0100, 0);
    run("alu_ri", op(C_ALU_RI), 2'd1, 2'd3, 4'b0001, 0);
    run("cmp_z1", op(C_CMP), 2'd0, 2'd1, 4'b0100, 0);
    run("br_eq", op(C_BR_EQ), 2'd0, 2'd0, 4'b0000, 0);
    run("cmp_z2", op(C_CMP), 2'd0, 2'd1, 4'b0100, 0);
    run("br_ne", op(C_BR_NE), 2'd0, 2'd0, 4'b1011, 0);
    run("br_gt_z", op(C_BR_GT), 2'd0, 2'd0, 4'b0000, 0);
    run("cmp_0", op(C_CMP), 2'd3, 2'd2, 4'b0000, 0);
    run("br_ge_0", op(C_BR_GE), 2'd0, 2'd0, 4'b0100, 0);
    run("br_gt_0", op(C_BR_GT), 2'd0, 2'd0, 4'b0100, 0);
    run("cmp_n", op(C_CMP), 2'd3, 2'd2, 4'b0010, 0);
    run("br_ge_n", op(C_BR_GE), 2'd0, 2'd0, 4'b0000, 0);
    run("br_gt_n", op(C_BR_GT), 2'd0, 2'd0, 4'b0000, 0);
    run("br_u", op(C_BR_U), 2'd0, 2'd0, 4'b0000, 0);
    run("nop", op(C_NOP), 2'd1, 2'd1, 4'b1111, 0);
    run("input", op(C_INPUT), 2'd3, 2'd0, 4'b0101, 0);
    run("load3", op(C_LOAD), 2'd1, 2'd2, 4'b1001, 3);
    run("load0", op(C_LOAD), 2'd2, 2'd3, 4'b0000, 0);
    run("store0", op(C_STORE), 2'd0, 2'd1, 4'b0110, 0);
    run("store2", op(C_STORE), 2'd3, 2'd3, 4'b0110, 2);
    run("ill_zero", '0, 2'd1, 2'd2, 4'b1111, 0);
    run("ill_two", op(C_ALU_RR) | op(C_ALU_RI),
        2'd2, 2'd1, 4'b1111, 0);
    run("cmp_set", op(C_CMP), 2'd0, 2'd0, 4'b1010, 0);

    // reset while a load is stalled in MEM
    bus.instr_valid = 1'b1;
    bus.opc_in = op(C_LOAD);
    bus.rx_in = 2'd2;
    step();
    bus.instr_valid = 1'b0;
    step();
    bus.mem_busy = 1'b1;
    step();
    step();
    chk("stall_phase", 32'(bus.phase), 32'(S_MEM));
    chk("stall_rd", 32'(bus.mem_rd), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mrst_phase", 32'(bus.phase), 32'(S_FETCH));
    chk("mrst_rd", 32'(bus.mem_rd), 32'd0);
    chk("mrst_flags", 32'(bus.flags_q), 32'd0);
    mflags = '0;
    rst_n = 1'b1;
    bus.mem_busy = 1'b0;
    run("after_rst", op(C_ALU_RR), 2'd3, 2'd0, 4'b1000, 0);

    run("halt", op(C_HALT), 2'd0, 2'd0, 4'b0000, 0);
    bad = 0;
    bus.instr_valid = 1'b1;
    bus.opc_in = op(C_ALU_RR);
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(bus.halted === 1'b1 && bus.instr_ready === 1'b0
            && bus.phase === S_HALT))
        bad++;
    end
    chk("halt_hold", 32'(bad), 32'd0);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("hrst_phase", 32'(bus.phase), 32'(S_FETCH));
    chk("hrst_halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;
    step();
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
